// File: rtl/rca_seq_ctrl_pkg.sv
// Shared definitions for the sequential nibble-serial adder: FSM encoding,
// nibble width and the signed-overflow helper.
package rca_seq_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Two's-complement overflow: operands agree in sign but the sum does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/rca_seq_ctrl_rca4.sv
// 4-bit ripple-carry adder built from a chain of full-adder cells.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic       co,
    output logic [3:0] s
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[4];
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Wide adder that reuses one rca4 across the operand, one nibble per clock,
// LSB nibble first, with valid/ready handshakes on both sides.
module rca_seq_ctrl
    import rca_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid are registered and never depend on the peer.
    state_e                state_q;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic [WIDTH-1:0]      s_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  carry_q;
    logic                  co_q;
    logic                  ovf_q;
    logic                  in_ready_q;
    logic                  out_valid_q;

    logic [NIBBLE_W-1:0]   nib_a;
    logic [NIBBLE_W-1:0]   nib_b;
    logic [NIBBLE_W-1:0]   nib_s;
    logic                  nib_co;

    always_comb begin
        nib_a = a_q[NIBBLE_W*int'(cnt_q) +: NIBBLE_W];
        nib_b = b_q[NIBBLE_W*int'(cnt_q) +: NIBBLE_W];
    end

    rca4 u_rca4 (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q),
        .co (nib_co),
        .s  (nib_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= ci;
                        cnt_q      <= '0;
                        s_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    s_q[NIBBLE_W*int'(cnt_q) +: NIBBLE_W] <= nib_s;
                    carry_q <= nib_co;
                    if (cnt_q == CNT_LAST) begin
                        // nib_s[3] is the sum MSB on the final nibble pass.
                        co_q        <= nib_co;
                        ovf_q       <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], nib_s[NIBBLE_W-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed plus randomized bench for rca_seq_ctrl, checked against an
// arithmetic reference model (sum = a + b + ci over WIDTH+1 bits).
module tb_rca_seq_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    // Expected results packed as {ovf, co, s}.
    logic [W+1:0] exp_q[$];

    rca_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mci);
        logic [W:0]   full;
        logic [W-1:0] sum;
        logic         sov;
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mci};
        sum  = full[W-1:0];
        sov  = (ma[W-1] == mb[W-1]) && (sum[W-1] != ma[W-1]);
        return {sov, full[W], sum};
    endfunction

    task automatic check_result(input string tag);
        logic [W+1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_s"},   32'(s),   32'(e[W-1:0]));
            check({tag, "_co"},  32'(co),  32'(e[W]));
            check({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n == 20) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // Issue one op, scramble inputs during ADD, check latency and result;
    // optionally hold out_ready low for hold_cycles first.
    task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic oci, input int hold_cycles);
        int lat = 0;
        logic [W-1:0] hs;
        logic hco, hovf;
        wait_ready(tag);
        a = oa; b = ob; ci = oci; in_valid = 1'b1; out_ready = 1'b0;
        exp_q.push_back(model(oa, ob, oci));
        step();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
            a = W'($urandom); b = W'($urandom);
        end
        check({tag, "_latency"}, 32'(lat), 32'(NIB));
        check_result(tag);
        hs = s; hco = co; hovf = ovf;
        for (int i = 0; i < hold_cycles; i++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom);
            step();
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_s"},     32'(s),        32'(hs));
            check({tag, "_hold_co_ovf"}, 32'({co, ovf}), 32'({hco, hovf}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_back_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin : stim
        int cyc;
        int acc_n;
        int acc_c[2];
        int pulse_n;
        int pulse_c[2];
        logic prev_ready;
        logic [W-1:0] ra, rb;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b0;
        step();
        step();
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_s",         32'(s),         32'd0);
        check("reset_co_ovf",    32'({co, ovf}), 32'd0);
        rst = 1'b0;
        step();

        run_op("carry_nibbles", 16'h1234, 16'h0FF0, 1'b0, 0);
        run_op("unsigned_wrap", 16'hFFFF, 16'h0001, 1'b0, 0);
        run_op("ci_in",         16'h000F, 16'h0000, 1'b1, 0);
        run_op("ovf_pos",       16'h7FFF, 16'h0001, 1'b0, 0);
        run_op("ovf_neg",       16'h8000, 16'h8000, 1'b0, 5);

        // Reset during the second ADD cycle discards the partial sum.
        wait_ready("mid_rst");
        a = 16'hABCD; b = 16'h1111; ci = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_s",         32'(s),         32'd0);
        for (int i = 0; i < NIB + 2; i++) begin
            step();
            check("mid_rst_no_pulse", 32'(out_valid), 32'd0);
        end
        run_op("after_rst", 16'h0002, 16'h0004, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op("random", ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
        end

        // Back-to-back with in_valid and out_ready held high.
        wait_ready("b2b");
        cyc = 0; acc_n = 0; pulse_n = 0;
        acc_c[0] = 0; acc_c[1] = 0; pulse_c[0] = 0; pulse_c[1] = 0;
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        in_valid = 1'b1; out_ready = 1'b1;
        while (pulse_n < 2 && cyc < 40) begin
            prev_ready = in_ready;
            step();
            cyc++;
            if (prev_ready === 1'b1 && in_valid === 1'b1) begin
                exp_q.push_back(model(a, b, ci));
                acc_c[acc_n] = cyc;
                acc_n++;
                a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
                if (acc_n == 2) in_valid = 1'b0;
            end
            if (out_valid === 1'b1) begin
                pulse_c[pulse_n] = cyc;
                pulse_n++;
                check_result("b2b");
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_pulses",       32'(pulse_n),                32'd2);
        check("b2b_pulse_gap",    32'(pulse_c[1] - pulse_c[0]), 32'(NIB + 2));
        check("b2b_second_accept", 32'(acc_c[1]),              32'(pulse_c[0] + 2));
        check("b2b_first_latency", 32'(pulse_c[0] - acc_c[0]), 32'(NIB));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
